// File: rtl/mul_arbiter_if.sv
// Bundle of requester, result and multiplier-side signals for the shared multiplier arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mul_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int REQ_NUM   = 4
);
    logic [REQ_NUM-1:0]                  req_valid;
    logic [REQ_NUM-1:0]                  req_ready;
    logic [REQ_NUM-1:0]                  req_sign;
    logic [REQ_NUM-1:0]                  req_diff_type;
    logic [REQ_NUM-1:0][DATA_SIZE-1:0]   req_data_1;
    logic [REQ_NUM-1:0][DATA_SIZE-1:0]   req_data_2;
    logic [REQ_NUM-1:0]                  res_valid;
    logic [REQ_NUM-1:0]                  res_ready;
    logic [REQ_NUM-1:0][2*DATA_SIZE-1:0] res_data;
    logic                                mul_enable;
    logic                                mul_sign;
    logic                                mul_diff_type;
    logic [DATA_SIZE-1:0]                mul_data_1;
    logic [DATA_SIZE-1:0]                mul_data_2;
    logic                                mul_ready;
    logic [2*DATA_SIZE-1:0]              mul_result;

    modport slave (
        input  req_valid, req_sign, req_diff_type, req_data_1, req_data_2,
        input  res_ready, mul_ready, mul_result,
        output req_ready, res_valid, res_data,
        output mul_enable, mul_sign, mul_diff_type, mul_data_1, mul_data_2
    );

    modport master (
        output req_valid, req_sign, req_diff_type, req_data_1, req_data_2,
        output res_ready, mul_ready, mul_result,
        input  req_ready, res_valid, res_data,
        input  mul_enable, mul_sign, mul_diff_type, mul_data_1, mul_data_2
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among REQ_NUM requesters,
// with credit-limited per-requester result FIFOs and a tag pipeline tracking ownership.
module mul_arbiter #(
    parameter int DATA_SIZE  = 32,
    parameter int REQ_NUM    = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    output logic         err,
    mul_arbiter_if.slave bus
);
    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WRM_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [WRM_W-1:0] WARM_DONE = WRM_W'(LATENCY);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(REQ_NUM - 1);

    logic                                run_q;
    logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0]                  tag_vld_q;
    logic [LATENCY-1:0][IDX_W-1:0]       tag_id_q;
    logic [REQ_NUM-1:0][CNT_W-1:0]       inflight_q;
    logic [REQ_NUM-1:0][CNT_W-1:0]       cnt_q;
    logic [REQ_NUM-1:0][PTR_W-1:0]       wr_ptr_q;
    logic [REQ_NUM-1:0][PTR_W-1:0]       rd_ptr_q;
    logic [2*DATA_SIZE-1:0]              mem_q [REQ_NUM][FIFO_DEPTH];
    logic [WRM_W-1:0]                    warm_q;
    logic                                err_q, err_d;

    logic [REQ_NUM-1:0]                  elig;
    logic [REQ_NUM-1:0]                  grant;
    logic                                grant_any;
    logic [IDX_W-1:0]                    grant_idx;
    logic [REQ_NUM-1:0]                  push;
    logic [REQ_NUM-1:0]                  pop;
    logic [REQ_NUM-1:0]                  res_valid_v;
    logic [REQ_NUM-1:0][2*DATA_SIZE-1:0] res_data_v;
    logic                                last_vld;
    logic [IDX_W-1:0]                    last_id;
    int                                  cand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign last_vld = tag_vld_q[LATENCY-1];
    assign last_id  = tag_id_q[LATENCY-1];

    // A requester only competes while it still holds a free result slot.
    always_comb begin
        elig        = '0;
        push        = '0;
        res_valid_v = '0;
        res_data_v  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            elig[i] = bus.req_valid[i] && run_q && !flush &&
                      (({1'b0, inflight_q[i]} + {1'b0, cnt_q[i]}) < DEPTH_C);
            push[i]        = last_vld && (last_id == IDX_W'(i));
            res_valid_v[i] = (cnt_q[i] != '0);
            res_data_v[i]  = mem_q[i][rd_ptr_q[i]];
        end
        pop = res_valid_v & bus.res_ready;
    end

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= REQ_NUM) cand = cand - REQ_NUM;
            if (!grant_any && elig[IDX_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant_any) rr_ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
    end

    // Flushed operations still return from the multiplier; the warm-up window masks them.
    assign err_d = err_q | ((warm_q == WARM_DONE) && (last_vld != bus.mul_ready));

    assign bus.req_ready     = grant;
    assign bus.mul_enable    = grant_any;
    assign bus.mul_sign      = grant_any & bus.req_sign[grant_idx];
    assign bus.mul_diff_type = grant_any & bus.req_diff_type[grant_idx];
    assign bus.mul_data_1    = grant_any ? bus.req_data_1[grant_idx] : '0;
    assign bus.mul_data_2    = grant_any ? bus.req_data_2[grant_idx] : '0;
    assign bus.res_valid     = res_valid_v;
    assign bus.res_data      = res_data_v;
    assign err               = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            rr_ptr_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            warm_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            if (flush)                   warm_q <= '0;
            else if (warm_q != WARM_DONE) warm_q <= warm_q + 1'b1;
            tag_id_q[0] <= grant_idx;
            for (int s = 1; s < LATENCY; s++) tag_id_q[s] <= tag_id_q[s-1];
            if (flush) begin
                tag_vld_q  <= '0;
                inflight_q <= '0;
                cnt_q      <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                tag_vld_q[0] <= grant_any;
                for (int s = 1; s < LATENCY; s++) tag_vld_q[s] <= tag_vld_q[s-1];
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (grant[i] && !push[i])      inflight_q[i] <= inflight_q[i] + 1'b1;
                    else if (push[i] && !grant[i]) inflight_q[i] <= inflight_q[i] - 1'b1;
                    if (push[i] && !pop[i])        cnt_q[i] <= cnt_q[i] + 1'b1;
                    else if (pop[i] && !push[i])   cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                    if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (push[i] && !flush) mem_q[i][wr_ptr_q[i]] <= bus.mul_result;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a 3-stage behavioural multiplier model.
module tb_mul_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic err;
    logic force_rdy = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mul_arbiter_if #(.DATA_SIZE(32), .REQ_NUM(4)) bus ();

    mul_arbiter #(.DATA_SIZE(32), .REQ_NUM(4), .LATENCY(3), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul_model(input logic s, input logic d,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (s) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (s && !d) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    logic [2:0]  p_vld;
    logic [63:0] p_res [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= '0;
        end else begin
            p_vld    <= {p_vld[1:0], bus.mul_enable};
            p_res[0] <= mul_model(bus.mul_sign, bus.mul_diff_type, bus.mul_data_1, bus.mul_data_2);
            p_res[1] <= p_res[0];
            p_res[2] <= p_res[1];
        end
    end
    assign bus.mul_ready  = p_vld[2] | force_rdy;
    assign bus.mul_result = p_res[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_sign      = '0;
        bus.req_diff_type = '0;
        bus.req_data_1    = '0;
        bus.req_data_2    = '0;
        bus.res_ready     = '1;
        flush             = 1'b0;
        force_rdy         = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data_1[0] = 32'd5;
        tick();
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready got %b exp 0000", bus.req_ready); end
        n_cmp++; if (bus.mul_enable !== 1'b0) begin n_err++; $display("FAIL rst_mul_enable got %b exp 0", bus.mul_enable); end
        n_cmp++; if (bus.mul_data_1 !== 32'd0) begin n_err++; $display("FAIL rst_mul_data_1 got %h exp 0", bus.mul_data_1); end
        n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL rst_res_valid got %b exp 0000", bus.res_valid); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", err); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL rst_release_cycle got %b exp 0000", bus.req_ready); end
        tick();
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant got %b exp 0001", bus.req_ready); end
        n_cmp++; if (bus.mul_data_1 !== 32'd5) begin n_err++; $display("FAIL rst_first_data got %h exp 5", bus.mul_data_1); end
        tick();
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data_1[0] = 32'd2;
        bus.req_data_2[0] = 32'd2;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL midop_grant got %b exp 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL midop_res_valid k=%0d got %b exp 0000", k, bus.res_valid); end
        end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL midop_err got %b exp 0", err); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data_1[2] = 32'd7;
        bus.req_data_2[2] = 32'd6;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b exp 0100", bus.req_ready); end
        n_cmp++; if (bus.mul_enable !== 1'b1) begin n_err++; $display("FAIL single_enable got %b exp 1", bus.mul_enable); end
        n_cmp++; if (bus.mul_data_1 !== 32'd7 || bus.mul_data_2 !== 32'd6) begin n_err++; $display("FAIL single_operands got %0d,%0d exp 7,6", bus.mul_data_1, bus.mul_data_2); end
        tick();
        bus.req_valid = '0;
        #1;
        n_cmp++; if (bus.mul_enable !== 1'b0) begin n_err++; $display("FAIL single_idle_enable got %b exp 0", bus.mul_enable); end
        tick();
        tick();
        n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL single_early_valid got %b exp 0000", bus.res_valid); end
        tick();
        n_cmp++; if (bus.res_valid !== 4'b0100) begin n_err++; $display("FAIL single_res_valid got %b exp 0100", bus.res_valid); end
        n_cmp++; if (bus.res_data[2] !== 64'd42) begin n_err++; $display("FAIL single_res_data got %0d exp 42", bus.res_data[2]); end
        tick();
        n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL single_after_pop got %b exp 0000", bus.res_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_data_1[i] = 32'(i + 1);
            bus.req_data_2[i] = 32'd10;
        end
        bus.req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            #1;
            exp_g = 4'b0001 << (k % 4);
            n_cmp++; if (bus.req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, bus.req_ready, exp_g); end
            n_cmp++; if (bus.mul_enable !== 1'b1) begin n_err++; $display("FAIL rr_enable k=%0d got %b exp 1", k, bus.mul_enable); end
            if (k >= 4) begin
                n_cmp++; if (bus.res_valid !== exp_g) begin n_err++; $display("FAIL rr_res_valid k=%0d got %b exp %b", k, bus.res_valid, exp_g); end
                n_cmp++; if (bus.res_data[k % 4] !== 64'((k % 4 + 1) * 10)) begin n_err++; $display("FAIL rr_res_data k=%0d got %0d exp %0d", k, bus.res_data[k % 4], (k % 4 + 1) * 10); end
            end
        end
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_credit();
        int accepts;
        accepts = 0;
        do_reset();
        bus.res_ready = 4'b0000;
        bus.req_valid = 4'b0001;
        bus.req_data_1[0] = 32'd3;
        bus.req_data_2[0] = 32'd4;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL credit_c0 got %b exp 0001", bus.req_ready); end
        if (bus.req_ready[0]) accepts++;
        tick();
        bus.req_data_1[0] = 32'd5;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL credit_c1 got %b exp 0001", bus.req_ready); end
        if (bus.req_ready[0]) accepts++;
        for (int k = 2; k < 7; k++) begin
            tick();
            n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL credit_blocked c=%0d got %b exp 0000", k, bus.req_ready); end
            if (bus.req_ready[0]) accepts++;
        end
        n_cmp++; if (bus.res_valid !== 4'b0001) begin n_err++; $display("FAIL credit_res_valid got %b exp 0001", bus.res_valid); end
        n_cmp++; if (bus.res_data[0] !== 64'd12) begin n_err++; $display("FAIL credit_head1 got %0d exp 12", bus.res_data[0]); end
        tick();
        bus.res_ready = 4'b0001;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL credit_pop_cycle got %b exp 0000", bus.req_ready); end
        if (bus.req_ready[0]) accepts++;
        n_cmp++; if (accepts !== 2) begin n_err++; $display("FAIL credit_accepts got %0d exp 2", accepts); end
        tick();
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL credit_freed got %b exp 0001", bus.req_ready); end
        n_cmp++; if (bus.res_data[0] !== 64'd20) begin n_err++; $display("FAIL credit_head2 got %0d exp 20", bus.res_data[0]); end
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_signed_order();
        do_reset();
        bus.res_ready = 4'b0000;
        bus.req_valid = 4'b0010;
        bus.req_sign[1] = 1'b1;
        bus.req_data_1[1] = 32'hFFFF_FFFD;
        bus.req_data_2[1] = 32'd5;
        #1;
        n_cmp++; if (bus.mul_sign !== 1'b1) begin n_err++; $display("FAIL signed_mul_sign got %b exp 1", bus.mul_sign); end
        tick();
        bus.req_sign[1] = 1'b0;
        bus.req_data_1[1] = 32'd2;
        bus.req_data_2[1] = 32'd9;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0010 || bus.mul_sign !== 1'b0) begin n_err++; $display("FAIL signed_second_issue got %b/%b exp 0010/0", bus.req_ready, bus.mul_sign); end
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        bus.res_ready = 4'b0010;
        #1;
        n_cmp++; if (bus.res_valid !== 4'b0010) begin n_err++; $display("FAIL signed_valid got %b exp 0010", bus.res_valid); end
        n_cmp++; if (bus.res_data[1] !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("FAIL signed_product got %h exp fffffffffffffff1", bus.res_data[1]); end
        tick();
        n_cmp++; if (bus.res_valid !== 4'b0010) begin n_err++; $display("FAIL order_valid got %b exp 0010", bus.res_valid); end
        n_cmp++; if (bus.res_data[1] !== 64'd18) begin n_err++; $display("FAIL order_second got %0d exp 18", bus.res_data[1]); end
        tick();
        n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL order_drained got %b exp 0000", bus.res_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data_1[3] = 32'd2;
        bus.req_data_2[3] = 32'd3;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL flush_issue0 got %b exp 1000", bus.req_ready); end
        tick();
        bus.req_data_1[3] = 32'd4;
        bus.req_data_2[3] = 32'd5;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL flush_issue1 got %b exp 1000", bus.req_ready); end
        tick();
        flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0 || bus.mul_enable !== 1'b0) begin n_err++; $display("FAIL flush_block got %b/%b exp 0000/0", bus.req_ready, bus.mul_enable); end
        tick();
        flush = 1'b0;
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            #1;
            n_cmp++; if (bus.res_valid !== 4'b0) begin n_err++; $display("FAIL flush_discard k=%0d got %b exp 0000", k, bus.res_valid); end
            n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL flush_err k=%0d got %b exp 0", k, err); end
        end
        tick();
        bus.req_valid = 4'b1000;
        bus.req_data_1[3] = 32'd6;
        bus.req_data_2[3] = 32'd7;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL flush_reissue got %b exp 1000", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        n_cmp++; if (bus.res_valid !== 4'b1000) begin n_err++; $display("FAIL flush_after_valid got %b exp 1000", bus.res_valid); end
        n_cmp++; if (bus.res_data[3] !== 64'd42) begin n_err++; $display("FAIL flush_after_data got %0d exp 42", bus.res_data[3]); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL flush_after_err got %b exp 0", err); end
        tick();
    endtask

    task automatic test_err();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        force_rdy = 1'b1;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_before got %b exp 0", err); end
        tick();
        force_rdy = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set got %b exp 1", err); end
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared got %b exp 0", err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_reset_midop();
        test_single();
        test_round_robin();
        test_credit();
        test_signed_order();
        test_flush();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
